// File: rtl/imem_loader_if.sv
// Byte-stream load port and core fetch port of the boot instruction memory.
// The master side is the stream source / core; the slave side is the loader.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [31:0]           fetch_data;

  modport master (
    output rx_data,
    output rx_valid,
    output fetch_addr,
    input  rx_ready,
    input  fetch_data
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  fetch_addr,
    output rx_ready,
    output fetch_data
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory. An image arrives as a byte stream:
//   len[7:0], len[15:8], len*4 little-endian data bytes, XOR checksum byte.
// The core is held in reset (core_run=0) until an image with a legal length
// and a matching checksum has been written into the store.
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic             clk,
  input  logic             clr,
  imem_loader_if.slave     bus,
  input  logic             reload,
  output logic             core_run,
  output logic             load_err,
  output logic [15:0]      word_count
);

  typedef enum logic [2:0] {
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHECK,
    ST_RUN,
    ST_ERROR
  } state_t;

  state_t                state_reg, state_next;
  logic [15:0]           len_reg, len_next;
  logic [1:0]            byte_idx_reg, byte_idx_next;
  logic [ADDR_WIDTH-1:0] waddr_reg, waddr_next;
  logic [7:0]            csum_reg, csum_next;
  logic                  core_run_reg, core_run_next;
  logic                  load_err_reg, load_err_next;
  logic [15:0]           word_count_reg, word_count_next;

  // Bytes 0..2 of the word being assembled; byte 3 goes straight to the store.
  logic [23:0]           word_buf_reg;
  logic [2:0]            lane_we;
  logic                  mem_we;
  logic                  accept;
  logic [15:0]           len_hdr;
  logic                  last_word;

  logic [31:0]           store [DEPTH];

  // Stream accepted only while loading, and never while clr is asserted.
  assign bus.rx_ready = ~clr & ((state_reg == ST_LEN_LO) | (state_reg == ST_LEN_HI) |
                                (state_reg == ST_DATA)   | (state_reg == ST_CHECK));
  assign accept       = bus.rx_valid & bus.rx_ready;

  // Full length as it will be once the high byte is latched.
  assign len_hdr      = {bus.rx_data, len_reg[7:0]};
  assign last_word    = (16'(waddr_reg) == (len_reg - 16'd1));

  // One write enable per low byte lane of the word buffer.
  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    assign lane_we[gi] = accept & (state_reg == ST_DATA) & (byte_idx_reg == 2'(gi));
  end

  // Next-state and datapath decisions; everything holds unless a case changes it.
  always_comb begin
    state_next      = state_reg;
    len_next        = len_reg;
    byte_idx_next   = byte_idx_reg;
    waddr_next      = waddr_reg;
    csum_next       = csum_reg;
    core_run_next   = core_run_reg;
    load_err_next   = load_err_reg;
    word_count_next = word_count_reg;
    mem_we          = 1'b0;
    case (state_reg)
      ST_LEN_LO: begin
        if (accept) begin
          len_next[7:0] = bus.rx_data;
          state_next    = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_next = len_hdr;
          if ((len_hdr == 16'd0) || ({16'd0, len_hdr} > 32'(DEPTH))) begin
            state_next    = ST_ERROR;
            load_err_next = 1'b1;
          end else begin
            state_next    = ST_DATA;
            byte_idx_next = 2'd0;
            waddr_next    = '0;
            csum_next     = 8'd0;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          csum_next     = csum_reg ^ bus.rx_data;
          byte_idx_next = byte_idx_reg + 2'd1;
          if (byte_idx_reg == 2'd3) begin
            mem_we     = 1'b1;
            waddr_next = waddr_reg + 1'b1;
            if (last_word) begin
              state_next = ST_CHECK;
            end
          end
        end
      end
      ST_CHECK: begin
        if (accept) begin
          if (bus.rx_data == csum_reg) begin
            state_next      = ST_RUN;
            core_run_next   = 1'b1;
            word_count_next = len_reg;
          end else begin
            state_next    = ST_ERROR;
            load_err_next = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (reload) begin
          state_next      = ST_LEN_LO;
          core_run_next   = 1'b0;
          word_count_next = 16'd0;
        end
      end
      ST_ERROR: begin
        if (reload) begin
          state_next    = ST_LEN_LO;
          load_err_next = 1'b0;
        end
      end
      default: begin
        state_next = ST_LEN_LO;
      end
    endcase
  end

  // Control registers; clr discards any partially loaded image.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg      <= ST_LEN_LO;
      len_reg        <= 16'd0;
      byte_idx_reg   <= 2'd0;
      waddr_reg      <= '0;
      csum_reg       <= 8'd0;
      core_run_reg   <= 1'b0;
      load_err_reg   <= 1'b0;
      word_count_reg <= 16'd0;
    end else begin
      state_reg      <= state_next;
      len_reg        <= len_next;
      byte_idx_reg   <= byte_idx_next;
      waddr_reg      <= waddr_next;
      csum_reg       <= csum_next;
      core_run_reg   <= core_run_next;
      load_err_reg   <= load_err_next;
      word_count_reg <= word_count_next;
    end
  end

  // Word assembly buffer; pure datapath, so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (lane_we[i]) begin
        word_buf_reg[i*8 +: 8] <= bus.rx_data;
      end
    end
  end

  // Store write on the byte-3 edge; contents survive clr.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      store[waddr_reg] <= {bus.rx_data, word_buf_reg};
    end
  end

  // Combinational fetch; anything outside the loaded image reads as zero.
  always_comb begin
    bus.fetch_data = 32'h0000_0000;
    if (core_run_reg && (16'(bus.fetch_addr) < word_count_reg)) begin
      bus.fetch_data = store[bus.fetch_addr];
    end
  end

  assign core_run   = core_run_reg;
  assign load_err   = load_err_reg;
  assign word_count = word_count_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. The driver streams images and pushes
// the expected load outcome into a queue; a monitor compares it when the DUT
// raises core_run or load_err. Fetch contents are checked against a reference
// image kept as a plain array.
module tb_imem_loader;

  logic        clk;
  logic        clr;
  logic        reload;
  logic        core_run;
  logic        load_err;
  logic [15:0] word_count;

  imem_loader_if #(.ADDR_WIDTH(8)) ifc ();

  imem_loader #(.ADDR_WIDTH(8), .DEPTH(256)) dut (
    .clk        (clk),
    .clr        (clr),
    .bus        (ifc),
    .reload     (reload),
    .core_run   (core_run),
    .load_err   (load_err),
    .word_count (word_count)
  );

  typedef struct {
    bit          run;
    bit          err;
    logic [15:0] wc;
    int          due;
  } outcome_t;

  int          errors = 0;
  int          checks = 0;
  int          cycle  = 0;
  outcome_t    exp_q[$];
  logic [31:0] ref_mem [256];
  bit          m_run;
  bit          m_err;
  logic [15:0] m_wc;
  bit          prev_run = 1'b0;
  bit          prev_err = 1'b0;
  int          load_no  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Outcome monitor: compares every rising core_run/load_err with the queue.
  always @(negedge clk) begin
    if ((core_run && !prev_run) || (load_err && !prev_err)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_outcome: got run=%0b err=%0b expected none", core_run, load_err);
      end else begin
        check("outcome_run", 32'(core_run), 32'(exp_q[0].run));
        check("outcome_err", 32'(load_err), 32'(exp_q[0].err));
        check("outcome_word_count", 32'(word_count), 32'(exp_q[0].wc));
        check("outcome_latency", cycle, exp_q[0].due);
        exp_q.delete(0);
      end
    end else if (exp_q.size() > 0 && cycle > exp_q[0].due) begin
      checks++;
      errors++;
      $display("FAIL outcome_timeout: got no outcome expected run=%0b err=%0b", exp_q[0].run, exp_q[0].err);
      exp_q.delete(0);
    end
    prev_run <= core_run;
    prev_err <= load_err;
  end

  function automatic logic [31:0] exp_fetch(input logic [7:0] a);
    if (m_run && (16'(a) < m_wc)) return ref_mem[a];
    return 32'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gap_mode: 0 none, 1 one idle cycle before every byte (rx_ready checked), 2 random
  task automatic send_byte(input logic [7:0] b, input int gap_mode);
    int gaps;
    int n;
    gaps = (gap_mode == 1) ? 1 : ((gap_mode == 2) ? int'($urandom_range(0, 2)) : 0);
    for (int g = 0; g < gaps; g++) begin
      ifc.rx_valid = 1'b0;
      ifc.rx_data  = 8'($urandom);
      @(negedge clk);
      if (gap_mode == 1) check("rx_ready_in_gap", 32'(ifc.rx_ready), 32'd1);
      tick();
    end
    ifc.rx_data  = b;
    ifc.rx_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ifc.rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_timeout: got 0 expected 1");
    end
    tick();
    ifc.rx_valid = 1'b0;
  endtask

  task automatic push_outcome(input bit run, input bit err, input logic [15:0] wc);
    outcome_t o;
    o.run = run;
    o.err = err;
    o.wc  = wc;
    o.due = cycle;
    exp_q.push_back(o);
  endtask

  // Streams one image; the expected result follows from the length rule and
  // the XOR of the data bytes. csum_flip != 0 corrupts the checksum byte.
  task automatic load_image(input logic [15:0] len, input logic [31:0] words[$],
                            input logic [7:0] csum_flip, input int gap_mode);
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [31:0] w;
    cs = 8'h00;
    load_no++;
    send_byte(len[7:0], gap_mode);
    send_byte(len[15:8], gap_mode);
    if (len == 16'd0 || len > 16'd256) begin
      push_outcome(1'b0, 1'b1, 16'd0);
      m_err = 1'b1;
      $display("load %0d: len=%0d bad length, expect error", load_no, len);
    end else begin
      for (int i = 0; i < int'(len); i++) begin
        w = words[i];
        for (int k = 0; k < 4; k++) begin
          b  = w[8*k +: 8];
          cs = cs ^ b;
          send_byte(b, gap_mode);
        end
        ref_mem[i] = w;
      end
      send_byte(cs ^ csum_flip, gap_mode);
      if (csum_flip == 8'h00) begin
        push_outcome(1'b1, 1'b0, len);
        m_run = 1'b1;
        m_wc  = len;
        $display("load %0d: len=%0d checksum %h, expect run", load_no, len, cs);
      end else begin
        push_outcome(1'b0, 1'b1, 16'd0);
        m_err = 1'b1;
        $display("load %0d: len=%0d checksum %h sent %h, expect error", load_no, len, cs, cs ^ csum_flip);
      end
    end
    @(negedge clk);
    tick();
  endtask

  task automatic do_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    m_run  = 1'b0;
    m_err  = 1'b0;
    m_wc   = 16'd0;
  endtask

  task automatic fetch_check(input logic [7:0] a);
    ifc.fetch_addr = a;
    @(negedge clk);
    check($sformatf("fetch[%0d]", a), ifc.fetch_data, exp_fetch(a));
    tick();
  endtask

  task automatic status_check(input string tag);
    @(negedge clk);
    check({tag, "_core_run"}, 32'(core_run), 32'(m_run));
    check({tag, "_load_err"}, 32'(load_err), 32'(m_err));
    check({tag, "_word_count"}, 32'(word_count), 32'(m_wc));
    tick();
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] empty_q[$];
    logic [15:0] len;
    int          r;

    clr            = 1'b1;
    reload         = 1'b0;
    ifc.rx_valid   = 1'b0;
    ifc.rx_data    = 8'h00;
    ifc.fetch_addr = 8'h00;
    m_run = 1'b0;
    m_err = 1'b0;
    m_wc  = 16'd0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;

    // Reset state
    ifc.rx_valid = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rx_ready_during_clr", 32'(ifc.rx_ready), 32'd0);
    tick();
    clr = 1'b0;
    ifc.rx_valid = 1'b0;
    status_check("reset");
    @(negedge clk);
    check("rx_ready_after_reset", 32'(ifc.rx_ready), 32'd1);
    check("fetch_after_reset", ifc.fetch_data, 32'h0);
    tick();

    // Known-good two-word image
    q = '{32'h11223344, 32'hAABBCCDD};
    load_image(16'd2, q, 8'h00, 0);
    fetch_check(8'd0);
    fetch_check(8'd1);
    fetch_check(8'd2);
    @(negedge clk);
    check("rx_ready_in_run", 32'(ifc.rx_ready), 32'd0);
    tick();

    // reload in RUN with a byte offered: byte must not be taken
    ifc.fetch_addr = 8'd0;
    ifc.rx_data    = 8'h03;
    ifc.rx_valid   = 1'b1;
    do_reload();
    ifc.rx_valid   = 1'b0;
    @(negedge clk);
    check("reload_core_run", 32'(core_run), 32'd0);
    check("reload_rx_ready", 32'(ifc.rx_ready), 32'd1);
    check("reload_fetch", ifc.fetch_data, 32'h0);
    check("reload_word_count", 32'(word_count), 32'd0);
    tick();

    // Same image, checksum 0x45
    load_image(16'd2, q, 8'h01, 0);
    @(negedge clk);
    check("rx_ready_in_error", 32'(ifc.rx_ready), 32'd0);
    tick();
    status_check("bad_csum");
    do_reload();
    @(negedge clk);
    check("err_reload_load_err", 32'(load_err), 32'd0);
    check("err_reload_rx_ready", 32'(ifc.rx_ready), 32'd1);
    tick();

    // Illegal length headers
    load_image(16'h0000, empty_q, 8'h00, 0);
    status_check("len_zero");
    do_reload();
    load_image(16'h0101, empty_q, 8'h00, 0);
    @(negedge clk);
    check("rx_ready_len_big", 32'(ifc.rx_ready), 32'd0);
    tick();
    do_reload();

    // One-word load with a gap before every byte
    q = '{32'h04030201};
    load_image(16'd1, q, 8'h00, 1);
    fetch_check(8'd0);
    fetch_check(8'd1);
    do_reload();

    // clr after six data bytes of a len=2 load
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    status_check("mid_clr");
    @(negedge clk);
    check("mid_clr_rx_ready", 32'(ifc.rx_ready), 32'd1);
    tick();
    q = '{$urandom, $urandom};
    load_image(16'd2, q, 8'h00, 0);
    fetch_check(8'd0);
    fetch_check(8'd1);

    // Randomized images
    for (int it = 0; it < 20; it++) begin
      if (m_run || m_err) do_reload();
      r = int'($urandom_range(0, 9));
      if (r == 0)      len = 16'd0;
      else if (r == 1) len = 16'(257 + $urandom_range(0, 60000));
      else             len = 16'($urandom_range(1, 6));
      q = {};
      if (len <= 16'd256) begin
        for (int i = 0; i < int'(len); i++) q.push_back($urandom);
      end
      load_image(len, q, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                 int'($urandom_range(0, 2)));
      status_check("random");
      if (m_run) begin
        fetch_check(8'($urandom_range(0, int'(len))));
        fetch_check(8'(len));
        fetch_check(8'd255);
      end
    end

    @(negedge clk);
    check("pending_outcomes", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
